// File: rtl/alu_decode_stage.sv
// alu_decode_stage: RV32I integer-ALU decode stage behind a 2-entry skid buffer.
// Instructions are decoded as they are accepted, and the decoded entries are stored.
// The output side always presents the oldest stored entry.
// in_ready is registered and de-asserts only while both entries are full.
// Optional feature: define DECODE_ILLEGAL_CNT_EN to enable a saturating
// 16-bit count of accepted illegal instructions.
// Without that macro, illegal_count is tied to zero.

module alu_decode_stage (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        flush,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_instr,
   input  logic [31:0] in_pc,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [3:0]  out_alu_op,
   output logic [31:0] out_imm,
   output logic        out_use_imm,
   output logic        out_use_pc,
   output logic [4:0]  out_rs1,
   output logic [4:0]  out_rs2,
   output logic [4:0]  out_rd,
   output logic        out_reg_write,
   output logic        out_illegal,
   output logic [31:0] out_pc,
   output logic [15:0] illegal_count
);

   // Buffer occupancy
   localparam logic [1:0] EMPTY = 2'd0;
   localparam logic [1:0] ONE   = 2'd1;
   localparam logic [1:0] TWO   = 2'd2;

   // ALU operation codes
   localparam logic [3:0] ALU_ADD  = 4'd0;
   localparam logic [3:0] ALU_SUB  = 4'd1;
   localparam logic [3:0] ALU_AND  = 4'd2;
   localparam logic [3:0] ALU_OR   = 4'd3;
   localparam logic [3:0] ALU_XOR  = 4'd4;
   localparam logic [3:0] ALU_SLL  = 4'd5;
   localparam logic [3:0] ALU_SRL  = 4'd6;
   localparam logic [3:0] ALU_SRA  = 4'd7;
   localparam logic [3:0] ALU_SLT  = 4'd8;
   localparam logic [3:0] ALU_SLTU = 4'd9;

   // Major opcodes handled by this stage
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   typedef struct packed {
      logic [3:0]  alu_op;
      logic [31:0] imm;
      logic        use_imm;
      logic        use_pc;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic        reg_write;
      logic        illegal;
      logic [31:0] pc;
   } entry_t;

   // funct3 -> ALU op for the non-alternate (funct7 = 0) encodings
   function automatic logic [3:0] base_op(input logic [2:0] f3);
      logic [3:0] op;
      case (f3)
         3'b000:  op = ALU_ADD;
         3'b001:  op = ALU_SLL;
         3'b010:  op = ALU_SLT;
         3'b011:  op = ALU_SLTU;
         3'b100:  op = ALU_XOR;
         3'b101:  op = ALU_SRL;
         3'b110:  op = ALU_OR;
         default: op = ALU_AND;
      endcase
      return op;
   endfunction

   logic [1:0] state_reg;
   logic [1:0] state_next;
   logic       in_ready_reg;
   logic       in_ready_next;
   entry_t     slot0_reg;
   entry_t     slot0_next;
   entry_t     slot1_reg;
   entry_t     slot1_next;
   entry_t     dec;
   logic       dec_illegal;
   logic       accept;
   logic       emit;

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic [6:0] funct7;

   assign opcode = in_instr[6:0];
   assign funct3 = in_instr[14:12];
   assign funct7 = in_instr[31:25];

   // Decode the incoming instruction into a storable entry
   always_comb begin
      dec           = '0;
      dec_illegal   = 1'b0;
      dec.pc        = in_pc;
      dec.rd        = in_instr[11:7];
      dec.rs1       = in_instr[19:15];
      dec.rs2       = in_instr[24:20];
      case (opcode)
         OPC_OP: begin
            dec.reg_write = 1'b1;
            if (funct7 == F7_BASE) begin
               dec.alu_op = base_op(funct3);
            end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
               dec.alu_op = ALU_SUB;
            end else if (funct7 == F7_ALT && funct3 == 3'b101) begin
               dec.alu_op = ALU_SRA;
            end else begin
               dec_illegal = 1'b1;
            end
         end
         OPC_OP_IMM: begin
            dec.reg_write = 1'b1;
            dec.use_imm   = 1'b1;
            dec.rs2       = 5'd0;
            dec.imm       = {{20{in_instr[31]}}, in_instr[31:20]};
            dec.alu_op    = base_op(funct3);
            // Shift-immediates carry only the shift amount; the upper
            // immediate bits are the funct7 selector, not part of the operand.
            if (funct3 == 3'b001) begin
               dec.imm = {27'd0, in_instr[24:20]};
               if (funct7 != F7_BASE) begin
                  dec_illegal = 1'b1;
               end
            end else if (funct3 == 3'b101) begin
               dec.imm = {27'd0, in_instr[24:20]};
               if (funct7 == F7_ALT) begin
                  dec.alu_op = ALU_SRA;
               end else if (funct7 != F7_BASE) begin
                  dec_illegal = 1'b1;
               end
            end
         end
         OPC_LUI, OPC_AUIPC: begin
            dec.reg_write = 1'b1;
            dec.use_imm   = 1'b1;
            dec.alu_op    = ALU_ADD;
            dec.rs1       = 5'd0;
            dec.rs2       = 5'd0;
            dec.imm       = {in_instr[31:12], 12'd0};
            dec.use_pc    = (opcode == OPC_AUIPC);
         end
         default: begin
            dec_illegal = 1'b1;
         end
      endcase
      // Illegal instructions must not drive any architectural side effect
      if (dec_illegal) begin
         dec.alu_op    = ALU_ADD;
         dec.reg_write = 1'b0;
         dec.use_imm   = 1'b0;
         dec.use_pc    = 1'b0;
         dec.imm       = 32'd0;
      end
      dec.illegal = dec_illegal;
   end

   // Flush suppresses both handshakes so nothing is stored or counted
   assign accept = in_valid & in_ready_reg & ~flush;
   assign emit   = (state_reg != EMPTY) & out_ready & ~flush;

   // Next occupancy and slot contents; slot0 is always the oldest entry
   always_comb begin
      state_next = state_reg;
      slot0_next = slot0_reg;
      slot1_next = slot1_reg;
      case (state_reg)
         EMPTY: begin
            if (accept) begin
               slot0_next = dec;
               state_next = ONE;
            end
         end
         ONE: begin
            if (accept && emit) begin
               slot0_next = dec;
            end else if (accept) begin
               slot1_next = dec;
               state_next = TWO;
            end else if (emit) begin
               state_next = EMPTY;
            end
         end
         TWO: begin
            if (emit) begin
               slot0_next = slot1_reg;
               state_next = ONE;
            end
         end
         default: begin
            state_next = EMPTY;
         end
      endcase
      if (flush) begin
         state_next = EMPTY;
      end
      in_ready_next = (state_next != TWO);
   end

   // Buffer state, registered ready and stored entries
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg    <= EMPTY;
         in_ready_reg <= 1'b0;
         slot0_reg    <= '0;
         slot1_reg    <= '0;
      end else begin
         state_reg    <= state_next;
         in_ready_reg <= in_ready_next;
         slot0_reg    <= slot0_next;
         slot1_reg    <= slot1_next;
      end
   end

`ifdef DECODE_ILLEGAL_CNT_EN
   logic [15:0] illegal_cnt_reg;

   // Saturating count of accepted illegal instructions; flush leaves it alone
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         illegal_cnt_reg <= 16'd0;
      end else if (accept && dec.illegal && illegal_cnt_reg != 16'hFFFF) begin
         illegal_cnt_reg <= illegal_cnt_reg + 16'd1;
      end
   end

   assign illegal_count = illegal_cnt_reg;
`else
   assign illegal_count = 16'd0;
`endif

   assign in_ready      = in_ready_reg;
   assign out_valid     = (state_reg != EMPTY);
   assign out_alu_op    = slot0_reg.alu_op;
   assign out_imm       = slot0_reg.imm;
   assign out_use_imm   = slot0_reg.use_imm;
   assign out_use_pc    = slot0_reg.use_pc;
   assign out_rs1       = slot0_reg.rs1;
   assign out_rs2       = slot0_reg.rs2;
   assign out_rd        = slot0_reg.rd;
   assign out_reg_write = slot0_reg.reg_write;
   assign out_illegal   = slot0_reg.illegal;
   assign out_pc        = slot0_reg.pc;

endmodule

// File: tb/tb_alu_decode_stage.sv
// Directed testbench for alu_decode_stage.
// Expected values are worked out by hand from the instruction encodings.
// The expected illegal_count depends on whether DECODE_ILLEGAL_CNT_EN is defined.

module tb_alu_decode_stage;

   logic        clk;
   logic        rst_n;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_instr;
   logic [31:0] in_pc;
   logic        out_valid;
   logic        out_ready;
   logic [3:0]  out_alu_op;
   logic [31:0] out_imm;
   logic        out_use_imm;
   logic        out_use_pc;
   logic [4:0]  out_rs1;
   logic [4:0]  out_rs2;
   logic [4:0]  out_rd;
   logic        out_reg_write;
   logic        out_illegal;
   logic [31:0] out_pc;
   logic [15:0] illegal_count;

   int checks = 0;
   int errors = 0;
   logic [15:0] exp_cnt3;

   alu_decode_stage dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .flush         (flush),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_instr      (in_instr),
      .in_pc         (in_pc),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_alu_op    (out_alu_op),
      .out_imm       (out_imm),
      .out_use_imm   (out_use_imm),
      .out_use_pc    (out_use_pc),
      .out_rs1       (out_rs1),
      .out_rs2       (out_rs2),
      .out_rd        (out_rd),
      .out_reg_write (out_reg_write),
      .out_illegal   (out_illegal),
      .out_pc        (out_pc),
      .illegal_count (illegal_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Global time bound so a broken design can never hang the run
   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "simulation time bound exceeded");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance one clock and settle just after the edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
`ifdef DECODE_ILLEGAL_CNT_EN
      exp_cnt3 = 16'd3;
`else
      exp_cnt3 = 16'd0;
`endif
      rst_n     = 1'b0;
      flush     = 1'b0;
      in_valid  = 1'b0;
      in_instr  = 32'd0;
      in_pc     = 32'd0;
      out_ready = 1'b0;

      // Reset state
      #2;
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
      chk("rst_out_pc", out_pc, 32'd0);
      chk("rst_illegal_count", {16'd0, illegal_count}, 32'd0);
      tick();
      tick();
      chk("rst_hold_in_ready", {31'd0, in_ready}, 32'd0);
      rst_n = 1'b1;
      tick();
      chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

      // ADD x3,x1,x2 with out_ready held high
      $display("txn ADD instr=002081b3 pc=00000100");
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_instr  = 32'h002081B3;
      in_pc     = 32'h0000_0100;
      tick();
      in_valid = 1'b0;
      chk("add_out_valid", {31'd0, out_valid}, 32'd1);
      chk("add_alu_op", {28'd0, out_alu_op}, 32'd0);
      chk("add_rs1", {27'd0, out_rs1}, 32'd1);
      chk("add_rs2", {27'd0, out_rs2}, 32'd2);
      chk("add_rd", {27'd0, out_rd}, 32'd3);
      chk("add_use_imm", {31'd0, out_use_imm}, 32'd0);
      chk("add_reg_write", {31'd0, out_reg_write}, 32'd1);
      chk("add_illegal", {31'd0, out_illegal}, 32'd0);
      chk("add_pc", out_pc, 32'h0000_0100);
      tick();
      chk("add_drained", {31'd0, out_valid}, 32'd0);

      // SRAI x5,x6,3 then ADDI x1,x0,-1 back to back
      $display("txn SRAI instr=40335293 pc=00000104");
      in_valid = 1'b1;
      in_instr = 32'h40335293;
      in_pc    = 32'h0000_0104;
      tick();
      chk("srai_alu_op", {28'd0, out_alu_op}, 32'd7);
      chk("srai_imm", out_imm, 32'd3);
      chk("srai_use_imm", {31'd0, out_use_imm}, 32'd1);
      chk("srai_rs1", {27'd0, out_rs1}, 32'd6);
      chk("srai_rs2", {27'd0, out_rs2}, 32'd0);
      chk("srai_rd", {27'd0, out_rd}, 32'd5);
      $display("txn ADDI instr=fff00093 pc=00000108");
      in_instr = 32'hFFF00093;
      in_pc    = 32'h0000_0108;
      tick();
      in_valid = 1'b0;
      chk("addi_out_valid", {31'd0, out_valid}, 32'd1);
      chk("addi_alu_op", {28'd0, out_alu_op}, 32'd0);
      chk("addi_imm", out_imm, 32'hFFFF_FFFF);
      chk("addi_rd", {27'd0, out_rd}, 32'd1);
      chk("addi_pc", out_pc, 32'h0000_0108);
      tick();
      chk("addi_drained", {31'd0, out_valid}, 32'd0);

      // LUI x5,0x12345
      $display("txn LUI instr=123452b7 pc=0000010c");
      in_valid = 1'b1;
      in_instr = 32'h123452B7;
      in_pc    = 32'h0000_010C;
      tick();
      in_valid = 1'b0;
      chk("lui_alu_op", {28'd0, out_alu_op}, 32'd0);
      chk("lui_rs1", {27'd0, out_rs1}, 32'd0);
      chk("lui_imm", out_imm, 32'h1234_5000);
      chk("lui_rd", {27'd0, out_rd}, 32'd5);
      chk("lui_use_pc", {31'd0, out_use_pc}, 32'd0);
      chk("lui_use_imm", {31'd0, out_use_imm}, 32'd1);
      tick();

      // AUIPC x2,0x1
      $display("txn AUIPC instr=00001117 pc=00000110");
      in_valid = 1'b1;
      in_instr = 32'h00001117;
      in_pc    = 32'h0000_0110;
      tick();
      in_valid = 1'b0;
      chk("auipc_use_pc", {31'd0, out_use_pc}, 32'd1);
      chk("auipc_imm", out_imm, 32'h0000_1000);
      chk("auipc_rd", {27'd0, out_rd}, 32'd2);
      tick();

      // SUB x2,x1,x2
      $display("txn SUB instr=40208133 pc=00000114");
      in_valid = 1'b1;
      in_instr = 32'h40208133;
      in_pc    = 32'h0000_0114;
      tick();
      in_valid = 1'b0;
      chk("sub_alu_op", {28'd0, out_alu_op}, 32'd1);
      tick();

      // funct7=0100000 on funct3=001 is illegal
      $display("txn BADOP instr=402091b3 pc=00000118");
      in_valid = 1'b1;
      in_instr = 32'h402091B3;
      in_pc    = 32'h0000_0118;
      tick();
      in_valid = 1'b0;
      chk("badop_illegal", {31'd0, out_illegal}, 32'd1);
      chk("badop_reg_write", {31'd0, out_reg_write}, 32'd0);
      chk("badop_alu_op", {28'd0, out_alu_op}, 32'd0);
      tick();

      // Backpressure: three offered while out_ready=0
      $display("txn BP_A instr=002081b3 pc=00000200");
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_instr  = 32'h002081B3;
      in_pc     = 32'h0000_0200;
      tick();
      chk("bp_one_in_ready", {31'd0, in_ready}, 32'd1);
      $display("txn BP_B instr=40208133 pc=00000204");
      in_instr = 32'h40208133;
      in_pc    = 32'h0000_0204;
      tick();
      chk("bp_two_in_ready", {31'd0, in_ready}, 32'd0);
      chk("bp_two_out_pc", out_pc, 32'h0000_0200);
      $display("txn BP_C instr=123452b7 pc=00000208");
      in_instr = 32'h123452B7;
      in_pc    = 32'h0000_0208;
      tick();
      chk("bp_hold_in_ready", {31'd0, in_ready}, 32'd0);
      chk("bp_hold_out_pc", out_pc, 32'h0000_0200);
      chk("bp_hold_alu_op", {28'd0, out_alu_op}, 32'd0);
      out_ready = 1'b1;
      tick();
      chk("bp_second_out_pc", out_pc, 32'h0000_0204);
      chk("bp_second_alu_op", {28'd0, out_alu_op}, 32'd1);
      chk("bp_reopen_in_ready", {31'd0, in_ready}, 32'd1);
      tick();
      in_valid = 1'b0;
      chk("bp_third_out_pc", out_pc, 32'h0000_0208);
      chk("bp_third_out_valid", {31'd0, out_valid}, 32'd1);
      tick();
      chk("bp_drained", {31'd0, out_valid}, 32'd0);

      // Three accepted illegal instructions, ending with both slots full
      $display("txn ILL x3 instr=00000000 pc=00000300");
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_instr  = 32'h0000_0000;
      in_pc     = 32'h0000_0300;
      tick();
      chk("ill_illegal", {31'd0, out_illegal}, 32'd1);
      chk("ill_reg_write", {31'd0, out_reg_write}, 32'd0);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      tick();
      in_valid = 1'b0;
      chk("ill_full_in_ready", {31'd0, in_ready}, 32'd0);
      chk("ill_count", {16'd0, illegal_count}, {16'd0, exp_cnt3});
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
      chk("flush_in_ready", {31'd0, in_ready}, 32'd1);
      chk("flush_count_kept", {16'd0, illegal_count}, {16'd0, exp_cnt3});

      // Flush with one entry stored and a new input offered: both are dropped
      $display("txn FLUSHDROP instr=002081b3 pc=00000400");
      in_valid = 1'b1;
      in_instr = 32'h002081B3;
      in_pc    = 32'h0000_0400;
      tick();
      chk("fd_one_out_valid", {31'd0, out_valid}, 32'd1);
      in_instr = 32'h0000_0000;
      in_pc    = 32'h0000_0404;
      flush    = 1'b1;
      tick();
      flush    = 1'b0;
      in_valid = 1'b0;
      chk("fd_out_valid", {31'd0, out_valid}, 32'd0);
      tick();
      chk("fd_stays_empty", {31'd0, out_valid}, 32'd0);
      chk("fd_count", {16'd0, illegal_count}, {16'd0, exp_cnt3});

      // Asynchronous reset while an entry is stored
      $display("txn MIDRST instr=002081b3 pc=00000500");
      in_valid = 1'b1;
      in_instr = 32'h002081B3;
      in_pc    = 32'h0000_0500;
      tick();
      in_valid = 1'b0;
      rst_n    = 1'b0;
      #1;
      chk("mrst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("mrst_in_ready", {31'd0, in_ready}, 32'd0);
      chk("mrst_out_pc", out_pc, 32'd0);
      chk("mrst_count", {16'd0, illegal_count}, 32'd0);
      tick();
      rst_n = 1'b1;
      tick();
      chk("mrst_in_ready_back", {31'd0, in_ready}, 32'd1);
      chk("mrst_still_empty", {31'd0, out_valid}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
